uart_rx_parity_engine: RTL and testbench

- Next-generation UART RX parity block.
- Accumulates parity bit-serially while data bits are sampled, instead of computing it over a parallel word.
- Supports runtime-selectable frame length and five parity modes (none/even/odd/mark/space).
- Reports per-frame result pulses plus sticky error status and a saturating error counter.
- Sits between the RX bit sampler and the RX FSM/deserializer; status outputs go to the register file.

---
 rtl/uart_parity_pkg.sv | 13 +
 rtl/uart_err_stat.sv | 35 +++
 rtl/uart_rx_parity_engine.sv | 114 +++++++++++
 tb/tb_uart_rx_parity_engine.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_parity_pkg.sv
// uart_parity_pkg: shared parity-mode codes, FSM state type and data-length clamp for the UART RX parity engine
package uart_parity_pkg;
  localparam logic [2:0] PAR_NONE  = 3'd0;
  localparam logic [2:0] PAR_EVEN  = 3'd1;
  localparam logic [2:0] PAR_ODD   = 3'd2;
  localparam logic [2:0] PAR_MARK  = 3'd3;
  localparam logic [2:0] PAR_SPACE = 3'd4;
  typedef enum logic [1:0] {IDLE, ACCUM, WAIT_PAR} state_t;
  // A length of 0 or anything beyond the datapath means "full width".
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    return (len == 0 || len > max_len) ? max_len : len;
  endfunction
endpackage

// File: rtl/uart_err_stat.sv
// uart_err_stat: sticky parity-error flag plus saturating error counter
//   CLK, RST (async, active-low)
//   i_set   : error event this cycle (sets flag, bumps counter)
//   i_clear : clear flag and counter (loses to a coincident i_set)
//   o_sticky, o_count : registered status
module uart_err_stat #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 i_set,
  input  logic                 i_clear,
  output logic                 o_sticky,
  output logic [CNT_WIDTH-1:0] o_count
);
  logic                 r_sticky;
  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] w_inc;
  always_comb w_inc = (r_count == {CNT_WIDTH{1'b1}}) ? r_count : r_count + CNT_WIDTH'(1);
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sticky <= 1'b0;
      r_count  <= '0;
    end else if (i_set) begin
      r_sticky <= 1'b1;
      // Clear and error together: the clear wipes history, the new error still counts.
      r_count  <= i_clear ? CNT_WIDTH'(1) : w_inc;
    end else if (i_clear) begin
      r_sticky <= 1'b0;
      r_count  <= '0;
    end
  end
  assign o_sticky = r_sticky;
  assign o_count  = r_count;
endmodule

// File: rtl/uart_rx_parity_engine.sv
// uart_rx_parity_engine: bit-serial UART RX parity checker with sequence checking and error statistics
//   CLK, RST (async, active-low)
//   Frame_Start, Data_Valid, Par_Valid, Sampled_bit : strobes/bit from the RX sampler
//   Parity_Mode, Data_Len : frame configuration, latched at Frame_Start
//   Err_Clear : clears Sticky_Error / Err_Count
//   Parity_Done, Parity_Error, Sequence_Error : one-cycle result pulses
//   Sticky_Error, Err_Count : status for the register file
module uart_rx_parity_engine
  import uart_parity_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Frame_Start,
  input  logic                 Data_Valid,
  input  logic                 Par_Valid,
  input  logic                 Sampled_bit,
  input  logic [2:0]           Parity_Mode,
  input  logic [LEN_W-1:0]     Data_Len,
  input  logic                 Err_Clear,
  output logic                 Parity_Done,
  output logic                 Parity_Error,
  output logic                 Sequence_Error,
  output logic                 Sticky_Error,
  output logic [CNT_WIDTH-1:0] Err_Count
);
  state_t           r_state;
  logic             r_acc;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len;
  logic [2:0]       r_mode;
  logic             r_done;
  logic             r_perr;
  logic             r_serr;
  logic             w_exp;
  logic [LEN_W-1:0] w_cnt_nx;
  logic             w_seq;
  logic             w_mis;
  logic             w_err_set;
  always_comb begin
    w_exp     = (r_mode == PAR_EVEN) ? r_acc : (r_mode == PAR_ODD) ? ~r_acc : (r_mode == PAR_MARK);
    w_cnt_nx  = r_cnt + LEN_W'(1);
    // Frame_Start pre-empts everything, so an aborted frame can never flag an error.
    w_seq     = !Frame_Start && Par_Valid && (r_state == ACCUM || (r_state == WAIT_PAR && Data_Valid));
    w_mis     = !Frame_Start && Par_Valid && r_state == WAIT_PAR && !Data_Valid && (Sampled_bit != w_exp);
    w_err_set = w_seq || w_mis;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_acc   <= 1'b0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_mode  <= PAR_NONE;
      r_done  <= 1'b0;
      r_perr  <= 1'b0;
      r_serr  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_perr <= 1'b0;
      r_serr <= 1'b0;
      if (Frame_Start) begin
        // Reserved mode codes are folded to "none" once here so later logic sees only legal codes.
        r_mode  <= (Parity_Mode > PAR_SPACE) ? PAR_NONE : Parity_Mode;
        r_len   <= LEN_W'(clamp_len(32'(Data_Len), DATA_WIDTH));
        r_acc   <= 1'b0;
        r_cnt   <= '0;
        r_state <= ACCUM;
      end else begin
        case (r_state)
          ACCUM: begin
            if (Par_Valid) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
              r_perr  <= 1'b1;
              r_serr  <= 1'b1;
            end else if (Data_Valid) begin
              r_acc <= r_acc ^ Sampled_bit;
              r_cnt <= w_cnt_nx;
              if (w_cnt_nx == r_len) begin
                r_state <= (r_mode == PAR_NONE) ? IDLE : WAIT_PAR;
                r_done  <= (r_mode == PAR_NONE);
              end
            end
          end
          WAIT_PAR: begin
            if (Par_Valid) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
              r_perr  <= w_err_set;
              r_serr  <= w_seq;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
  // Fed from the same-cycle error decision so status updates alongside the Parity_Error pulse.
  uart_err_stat #(.CNT_WIDTH(CNT_WIDTH)) u_err_stat (
    .CLK      (CLK),
    .RST      (RST),
    .i_set    (w_err_set),
    .i_clear  (Err_Clear),
    .o_sticky (Sticky_Error),
    .o_count  (Err_Count)
  );
  assign Parity_Done    = r_done;
  assign Parity_Error   = r_perr;
  assign Sequence_Error = r_serr;
endmodule

// File: tb/tb_uart_rx_parity_engine.sv
// tb_uart_rx_parity_engine: directed self-checking bench for uart_rx_parity_engine
module tb_uart_rx_parity_engine;
  logic       CLK;
  logic       RST;
  logic       Frame_Start;
  logic       Data_Valid;
  logic       Par_Valid;
  logic       Sampled_bit;
  logic [2:0] Parity_Mode;
  logic [3:0] Data_Len;
  logic       Err_Clear;
  logic       Parity_Done, Parity_Error, Sequence_Error, Sticky_Error;
  logic [7:0] Err_Count;
  logic       d2_done, d2_perr, d2_serr, d2_sticky;
  logic [1:0] d2_count;
  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int done_base;
  uart_rx_parity_engine dut (
    .CLK(CLK), .RST(RST), .Frame_Start(Frame_Start), .Data_Valid(Data_Valid),
    .Par_Valid(Par_Valid), .Sampled_bit(Sampled_bit), .Parity_Mode(Parity_Mode),
    .Data_Len(Data_Len), .Err_Clear(Err_Clear), .Parity_Done(Parity_Done),
    .Parity_Error(Parity_Error), .Sequence_Error(Sequence_Error),
    .Sticky_Error(Sticky_Error), .Err_Count(Err_Count)
  );
  uart_rx_parity_engine #(.CNT_WIDTH(2)) dut2 (
    .CLK(CLK), .RST(RST), .Frame_Start(Frame_Start), .Data_Valid(Data_Valid),
    .Par_Valid(Par_Valid), .Sampled_bit(Sampled_bit), .Parity_Mode(Parity_Mode),
    .Data_Len(Data_Len), .Err_Clear(Err_Clear), .Parity_Done(d2_done),
    .Parity_Error(d2_perr), .Sequence_Error(d2_serr),
    .Sticky_Error(d2_sticky), .Err_Count(d2_count)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(negedge CLK) if (Parity_Done) done_cnt++;
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic [2:0] mode, input logic [3:0] len);
    Frame_Start = 1'b1;
    Parity_Mode = mode;
    Data_Len    = len;
    tick;
    Frame_Start = 1'b0;
  endtask
  task automatic send_bit(input logic b);
    Data_Valid  = 1'b1;
    Sampled_bit = b;
    tick;
    Data_Valid  = 1'b0;
  endtask
  task automatic send_word(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[i]);
  endtask
  task automatic send_par(input logic b);
    Par_Valid   = 1'b1;
    Sampled_bit = b;
    tick;
    Par_Valid   = 1'b0;
  endtask
  task automatic err_frame;
    start(3'd3, 4'd1);
    send_bit(1'b0);
    send_par(1'b0);
  endtask
  initial begin
    RST = 1'b0; Frame_Start = 1'b0; Data_Valid = 1'b0; Par_Valid = 1'b0;
    Sampled_bit = 1'b0; Parity_Mode = 3'd0; Data_Len = 4'd0; Err_Clear = 1'b0;
    repeat (2) tick;
    chk("rst_done", Parity_Done, 0);
    chk("rst_perr", Parity_Error, 0);
    chk("rst_serr", Sequence_Error, 0);
    chk("rst_sticky", Sticky_Error, 0);
    chk("rst_count", Err_Count, 0);
    RST = 1'b1;
    tick;
    start(3'd1, 4'd8);
    Parity_Mode = 3'd0;
    Data_Len    = 4'd1;
    send_word(8'hA5, 8);
    chk("even_no_early_done", Parity_Done, 0);
    send_par(1'b0);
    chk("even_done", Parity_Done, 1);
    chk("even_perr", Parity_Error, 0);
    chk("even_count", Err_Count, 0);
    tick;
    chk("even_done_one_cycle", Parity_Done, 0);
    start(3'd2, 4'd7);
    send_word(8'h13, 7);
    send_par(1'b1);
    chk("odd_done", Parity_Done, 1);
    chk("odd_perr", Parity_Error, 1);
    chk("odd_sticky", Sticky_Error, 1);
    chk("odd_count", Err_Count, 1);
    tick;
    chk("odd_perr_one_cycle", Parity_Error, 0);
    chk("odd_sticky_held", Sticky_Error, 1);
    Err_Clear = 1'b1;
    tick;
    Err_Clear = 1'b0;
    chk("clear_sticky", Sticky_Error, 0);
    chk("clear_count", Err_Count, 0);
    start(3'd3, 4'd8);
    send_word(8'h00, 8);
    send_par(1'b0);
    chk("mark_perr", Parity_Error, 1);
    chk("mark_count", Err_Count, 1);
    start(3'd4, 4'd8);
    send_word(8'hFF, 8);
    send_par(1'b0);
    chk("space_done", Parity_Done, 1);
    chk("space_perr", Parity_Error, 0);
    start(3'd0, 4'd5);
    send_word(8'h1F, 4);
    chk("none_no_early_done", Parity_Done, 0);
    send_bit(1'b1);
    chk("none_done", Parity_Done, 1);
    chk("none_perr", Parity_Error, 0);
    chk("none_serr", Sequence_Error, 0);
    start(3'd1, 4'd8);
    send_word(8'h07, 3);
    send_par(1'b0);
    chk("seq_done", Parity_Done, 1);
    chk("seq_perr", Parity_Error, 1);
    chk("seq_serr", Sequence_Error, 1);
    chk("seq_count", Err_Count, 2);
    send_par(1'b1);
    chk("idle_par_ignored", Parity_Done, 0);
    send_bit(1'b1);
    chk("idle_data_ignored", Parity_Done, 0);
    done_base = done_cnt;
    start(3'd1, 4'd8);
    send_word(8'h0F, 4);
    start(3'd1, 4'd8);
    send_word(8'hFF, 8);
    send_par(1'b0);
    chk("abort_done", Parity_Done, 1);
    chk("abort_perr", Parity_Error, 0);
    tick;
    chk("abort_single_done", done_cnt - done_base, 1);
    start(3'd1, 4'd0);
    send_word(8'h01, 8);
    chk("len0_no_done", Parity_Done, 0);
    send_par(1'b1);
    chk("len0_done", Parity_Done, 1);
    chk("len0_perr", Parity_Error, 0);
    start(3'd5, 4'd3);
    send_word(8'h07, 3);
    chk("mode5_none_done", Parity_Done, 1);
    chk("mode5_none_perr", Parity_Error, 0);
    start(3'd7, 4'd9);
    send_word(8'h00, 7);
    chk("len9_no_early_done", Parity_Done, 0);
    send_bit(1'b0);
    chk("len9_done", Parity_Done, 1);
    start(3'd1, 4'd1);
    send_bit(1'b0);
    Data_Valid = 1'b1; Par_Valid = 1'b1; Sampled_bit = 1'b0;
    tick;
    Data_Valid = 1'b0; Par_Valid = 1'b0;
    chk("dual_serr", Sequence_Error, 1);
    chk("dual_perr", Parity_Error, 1);
    chk("dual_count", Err_Count, 3);
    Err_Clear = 1'b1;
    tick;
    Err_Clear = 1'b0;
    chk("sat_pre_clear", d2_count, 0);
    for (int i = 0; i < 5; i++) err_frame;
    chk("sat_count_w2", d2_count, 3);
    chk("sat_count_w8", Err_Count, 5);
    start(3'd3, 4'd1);
    send_bit(1'b0);
    Err_Clear = 1'b1;
    send_par(1'b0);
    Err_Clear = 1'b0;
    chk("clr_vs_err_count_w2", d2_count, 1);
    chk("clr_vs_err_sticky_w2", d2_sticky, 1);
    chk("clr_vs_err_count_w8", Err_Count, 1);
    start(3'd1, 4'd1);
    send_bit(1'b1);
    chk("pre_reset_sticky", Sticky_Error, 1);
    #2 RST = 1'b0;
    #1;
    chk("async_rst_sticky", Sticky_Error, 0);
    chk("async_rst_count", Err_Count, 0);
    chk("async_rst_done", Parity_Done, 0);
    chk("async_rst_perr", Parity_Error, 0);
    tick;
    RST = 1'b1;
    send_par(1'b1);
    chk("post_rst_par_ignored", Parity_Done, 0);
    tick;
    chk("post_rst_no_error", Parity_Error, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
